// File: rtl/bnn_popacc_thresh.sv
// Accumulates NBEATS popcount beats into one neuron match count and thresholds it.
// Result is held in HOLD until the consumer takes it; clr aborts a partial neuron only.
module bnn_popacc_thresh #(
  parameter int CWIDTH = 4,
  parameter int NBEATS = 8,
  parameter int AWIDTH = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CWIDTH-1:0] i_in_cnt,
  input  logic [AWIDTH-1:0] i_thr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_bit,
  output logic [AWIDTH-1:0] o_out_sum
);

  localparam int BW = $clog2(NBEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]        r_state;
  logic [BW-1:0]     r_beat;
  logic [AWIDTH-1:0] r_acc;
  logic [AWIDTH-1:0] r_thr;
  logic [AWIDTH-1:0] r_out_sum;
  logic              r_out_bit;

  logic              w_accept;
  logic [AWIDTH-1:0] w_cnt_ext;
  logic [AWIDTH-1:0] w_sum;

  // in_ready is gated by rst so it reads 0 for the whole reset pulse
  assign o_in_ready  = (r_state == S_ACC) && !i_rst;
  assign w_accept    = i_in_valid && (r_state == S_ACC) && !i_clr;
  assign w_cnt_ext   = AWIDTH'(i_in_cnt);
  assign w_sum       = r_acc + w_cnt_ext;

  assign o_out_valid = (r_state == S_HOLD);
  assign o_out_bit   = r_out_bit;
  assign o_out_sum   = r_out_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_ACC;
      r_beat    <= '0;
      r_acc     <= '0;
      r_thr     <= '0;
      r_out_sum <= '0;
      r_out_bit <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (i_clr) begin
            r_beat <= '0;
            r_acc  <= '0;
          end else if (w_accept) begin
            if (r_beat == '0) begin
              r_acc  <= w_cnt_ext;
              r_thr  <= i_thr;
              r_beat <= r_beat + 1'b1;
            end else if (r_beat == LAST_BEAT) begin
              r_out_sum <= w_sum;
              r_out_bit <= (w_sum >= r_thr);
              r_beat    <= '0;
              r_state   <= S_HOLD;
            end else begin
              r_acc  <= w_sum;
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (i_out_ready) r_state <= S_ACC;
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_popacc_thresh.sv
// Directed bench for bnn_popacc_thresh: vector table of whole neurons plus
// hand-written backpressure, clr and async-reset sequences.
module tb_bnn_popacc_thresh;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_cnt = 4'd0;
  logic [6:0] thr = 7'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_bit;
  logic [6:0] out_sum;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string           name;
    logic [6:0]      thr;
    logic [7:0][3:0] cnts;
    bit              gaps;
    logic [6:0]      exp_sum;
    logic            exp_bit;
  } vec_t;

  vec_t vecs[8];

  bnn_popacc_thresh #(.CWIDTH(4), .NBEATS(8), .AWIDTH(7)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (clr),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_cnt    (in_cnt),
    .i_thr       (thr),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_bit   (out_bit),
    .o_out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", nm, act);
    end
  endtask

  // Presents 8 beats; thr is only valid on beat 0, later beats carry a decoy value.
  task automatic send_neuron(input string nm, input logic [6:0] t,
                             input logic [7:0][3:0] cnts, input bit gaps,
                             input logic [6:0] exp_sum, input logic exp_bit);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        in_cnt   = 4'hF;
        cycle();
      end
      in_valid = 1'b1;
      in_cnt   = cnts[i];
      thr      = (i == 0) ? t : ~t;
      cycle();
      if (i == 6) chk({nm, " out_valid before last beat"}, 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " in_ready in HOLD"}, 32'(in_ready), 32'd0);
    chk({nm, " out_sum"}, 32'(out_sum), 32'(exp_sum));
    chk({nm, " out_bit"}, 32'(out_bit), 32'(exp_bit));
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk({nm, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    chk({nm, " in_ready after handshake"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0][3:0] all15, all1, all2;
    all15 = {8{4'd15}};
    all1  = {8{4'd1}};
    all2  = {8{4'd2}};

    vecs[0] = '{"nominal thr64",   7'd64,  {8{4'd8}}, 1'b0, 7'd64,  1'b1};
    vecs[1] = '{"edge thr65",      7'd65,  {8{4'd8}}, 1'b0, 7'd64,  1'b0};
    vecs[2] = '{"thr0",            7'd0,   {8{4'd8}}, 1'b0, 7'd64,  1'b1};
    vecs[3] = '{"max gaps thr120", 7'd120, {8{4'd15}}, 1'b1, 7'd120, 1'b1};
    vecs[4] = '{"above max thr121",7'd121, {8{4'd15}}, 1'b0, 7'd120, 1'b0};
    vecs[5] = '{"ramp thr28",      7'd28,
                {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0, 7'd28, 1'b1};
    vecs[6] = '{"mixed thr41",     7'd41,
                {4'd15, 4'd0, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b1, 7'd40, 1'b0};
    vecs[7] = '{"zeros thr0",      7'd0,   {8{4'd0}}, 1'b0, 7'd0,   1'b1};

    // Reset state while rst is held
    #2;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_sum", 32'(out_sum), 32'd0);
    chk("reset out_bit", 32'(out_bit), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("in_ready after reset release", 32'(in_ready), 32'd1);

    for (int v = 0; v < 8; v++) begin
      send_neuron(vecs[v].name, vecs[v].thr, vecs[v].cnts, vecs[v].gaps,
                  vecs[v].exp_sum, vecs[v].exp_bit);
      handshake(vecs[v].name);
    end

    // Backpressure: output held, beats ignored, then immediate next neuron
    send_neuron("bp", 7'd100, all15, 1'b0, 7'd120, 1'b1);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_cnt   = 4'd9;
      cycle();
      chk("bp held out_valid", 32'(out_valid), 32'd1);
      chk("bp held out_sum", 32'(out_sum), 32'd120);
      chk("bp held out_bit", 32'(out_bit), 32'd1);
      chk("bp held in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    send_neuron("bp next", 7'd8, all1, 1'b0, 7'd8, 1'b1);
    handshake("bp next");

    // clr mid-neuron discards 3 beats of 15; the clr beat itself is ignored
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_cnt   = 4'd15;
      thr      = (i == 0) ? 7'd127 : 7'd0;
      cycle();
    end
    clr      = 1'b1;
    in_valid = 1'b1;
    in_cnt   = 4'd15;
    #1;
    chk("clr in_ready", 32'(in_ready), 32'd1);
    cycle();
    clr = 1'b0;
    send_neuron("after clr", 7'd8, all1, 1'b0, 7'd8, 1'b1);

    // clr in HOLD must not disturb the completed result
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr in HOLD out_valid", 32'(out_valid), 32'd1);
    chk("clr in HOLD out_sum", 32'(out_sum), 32'd8);
    chk("clr in HOLD out_bit", 32'(out_bit), 32'd1);
    handshake("clr hold");

    // Async reset between edges after 5 beats
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_cnt   = 4'd15;
      thr      = 7'd0;
      cycle();
    end
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_sum", 32'(out_sum), 32'd0);
    chk("async rst out_bit", 32'(out_bit), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("in_ready after async rst", 32'(in_ready), 32'd1);
    send_neuron("after rst", 7'd16, all2, 1'b0, 7'd16, 1'b1);
    handshake("after rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
